// File: rtl/mmu_responder.sv
`default_nettype none
// ============================================================================
// Module      : mmu_responder
// Description : Captures instruction/data requests and serves them over one
//               backing bus in write, data-read, instruction-read order.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_responder #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_rden,
  input  logic [31:0] inst_riaddr,
  output logic        inst_rvalid,
  output logic [31:0] inst_roaddr,
  output logic [31:0] inst_rdata,
  input  logic        data_rden,
  input  logic [31:0] data_riaddr,
  output logic        data_rvalid,
  output logic [31:0] data_roaddr,
  output logic [31:0] data_rdata,
  input  logic        data_wren,
  input  logic [31:0] data_waddr,
  input  logic [31:0] data_wdata,
  output logic        mem_wait,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    DREAD = 3'd2,
    IREAD = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

  state_t      r_state, w_state;
  logic        r_pend_w, r_pend_d, r_pend_i;
  logic        w_pend_w, w_pend_d, w_pend_i;
  logic [31:0] r_w_addr, r_w_data, r_d_addr, r_i_addr;
  logic [31:0] w_w_addr, w_w_data, w_d_addr, w_i_addr;
  logic [31:0] r_d_res, r_i_res, w_d_res, w_i_res;
  logic [7:0]  r_cnt, w_cnt;
  logic        w_capture, w_timeout, w_done, w_access;
  logic [31:0] w_mem_addr, w_mem_wdata;

  logic        r_mem_req, r_mem_we, r_mem_wait, r_bus_err;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic        r_inst_rvalid, r_data_rvalid;
  logic [31:0] r_inst_roaddr, r_inst_rdata, r_data_roaddr, r_data_rdata;

  always_comb begin
    w_state   = r_state;
    w_pend_w  = r_pend_w;
    w_pend_d  = r_pend_d;
    w_pend_i  = r_pend_i;
    w_w_addr  = r_w_addr;
    w_w_data  = r_w_data;
    w_d_addr  = r_d_addr;
    w_i_addr  = r_i_addr;
    w_d_res   = r_d_res;
    w_i_res   = r_i_res;
    w_cnt     = r_cnt;
    w_timeout = 1'b0;
    w_done    = 1'b0;
    w_capture = ((r_state == IDLE) || (r_state == RESP)) &&
                (inst_rden || data_rden || data_wren);

    case (r_state)
      IDLE, RESP: begin
        if (w_capture) begin
          w_pend_w = data_wren;
          w_pend_d = data_rden;
          w_pend_i = inst_rden;
          if (data_wren) begin
            w_w_addr = data_waddr;
            w_w_data = data_wdata;
          end
          if (data_rden) w_d_addr = data_riaddr;
          if (inst_rden) w_i_addr = inst_riaddr;
          w_state = data_wren ? WRITE : (data_rden ? DREAD : IREAD);
        end else begin
          w_pend_w = 1'b0;
          w_pend_d = 1'b0;
          w_pend_i = 1'b0;
          w_state  = IDLE;
        end
      end
      WRITE, DREAD, IREAD: begin
        w_timeout = !mem_ack && (r_cnt == c_tmo_last);
        w_done    = mem_ack || w_timeout;
        if (!w_done) w_cnt = r_cnt + 8'd1;
        // A timed-out read returns zero rather than whatever the bus shows.
        if (w_done && (r_state == DREAD)) w_d_res = mem_ack ? mem_rdata : 32'h0;
        if (w_done && (r_state == IREAD)) w_i_res = mem_ack ? mem_rdata : 32'h0;
        if (w_done) begin
          if ((r_state == WRITE) && r_pend_d)      w_state = DREAD;
          else if ((r_state != IREAD) && r_pend_i) w_state = IREAD;
          else                                     w_state = RESP;
        end
      end
      default: w_state = IDLE;
    endcase

    if (w_done || w_capture) w_cnt = 8'd0;

    w_access    = (w_state == WRITE) || (w_state == DREAD) || (w_state == IREAD);
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    case (w_state)
      WRITE: begin
        w_mem_addr  = w_w_addr;
        w_mem_wdata = w_w_data;
      end
      DREAD:   w_mem_addr = w_d_addr;
      IREAD:   w_mem_addr = w_i_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pend_w      <= 1'b0;
      r_pend_d      <= 1'b0;
      r_pend_i      <= 1'b0;
      r_w_addr      <= 32'h0;
      r_w_data      <= 32'h0;
      r_d_addr      <= 32'h0;
      r_i_addr      <= 32'h0;
      r_d_res       <= 32'h0;
      r_i_res       <= 32'h0;
      r_cnt         <= 8'd0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_wait    <= 1'b0;
      r_mem_addr    <= 32'h0;
      r_mem_wdata   <= 32'h0;
      r_bus_err     <= 1'b0;
      r_inst_rvalid <= 1'b0;
      r_inst_roaddr <= 32'h0;
      r_inst_rdata  <= 32'h0;
      r_data_rvalid <= 1'b0;
      r_data_roaddr <= 32'h0;
      r_data_rdata  <= 32'h0;
    end else begin
      r_state     <= w_state;
      r_pend_w    <= w_pend_w;
      r_pend_d    <= w_pend_d;
      r_pend_i    <= w_pend_i;
      r_w_addr    <= w_w_addr;
      r_w_data    <= w_w_data;
      r_d_addr    <= w_d_addr;
      r_i_addr    <= w_i_addr;
      r_d_res     <= w_d_res;
      r_i_res     <= w_i_res;
      r_cnt       <= w_cnt;
      r_mem_req   <= w_access;
      r_mem_wait  <= w_access;
      r_mem_we    <= (w_state == WRITE);
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_bus_err   <= w_timeout;
      // Response registers load only as RESP is entered and hold otherwise.
      r_data_rvalid <= (w_state == RESP) && w_pend_d;
      r_inst_rvalid <= (w_state == RESP) && w_pend_i;
      if ((w_state == RESP) && w_pend_d) begin
        r_data_roaddr <= w_d_addr;
        r_data_rdata  <= w_d_res;
      end
      if ((w_state == RESP) && w_pend_i) begin
        r_inst_roaddr <= w_i_addr;
        r_inst_rdata  <= w_i_res;
      end
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_wait    = r_mem_wait;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign bus_err     = r_bus_err;
  assign inst_rvalid = r_inst_rvalid;
  assign inst_roaddr = r_inst_roaddr;
  assign inst_rdata  = r_inst_rdata;
  assign data_rvalid = r_data_rvalid;
  assign data_roaddr = r_data_roaddr;
  assign data_rdata  = r_data_rdata;

endmodule
`default_nettype wire
